// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple dual-port BRAM controller and its storage array.
package bram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Address width for n words, never narrower than one bit.
    function automatic int bram_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Storage array for bram_sdp_ctrl: per-lane write port and one registered read port.
// Out-of-range addresses are never indexed; such reads return zero.
module bram_sdp_array
    import bram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int BYTE_W = 8,
    parameter int AW     = bram_clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [DATA_W/BYTE_W-1:0]   i_wbe,
    input  logic                       i_re,
    input  logic [AW-1:0]              i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);
    localparam int          NB      = DATA_W / BYTE_W;
    localparam logic [31:0] DEPTH_U = DEPTH;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // No reset on the array itself so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < DEPTH_U)) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wbe[b]) r_mem[i_waddr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (32'(i_raddr) < DEPTH_U) ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_sdp_ctrl.sv
// Simple dual-port BRAM controller: byte-lane writes, RD_LAT-cycle pipelined reads, array clear FSM.
// Build option BRAM_WR_FWD_EN: same-address write+read returns the merged (write-first) word.
//   state | meaning
//   IDLE  | host reads/writes accepted; waits for clr_req or post-reset init
//   CLEAR | zeroes one word per cycle from address 0 to DEPTH-1; busy=1, host ignored
module bram_sdp_ctrl
    import bram_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 1024,
    parameter  int BYTE_W    = 8,
    parameter  int RD_LAT    = 1,
    parameter  int INIT_ZERO = 1,
    localparam int AW        = bram_clog2(DEPTH),
    localparam int NB        = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy
);
    localparam logic [31:0]   DEPTH_U   = DEPTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("bram_sdp_ctrl: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % BYTE_W) != 0) begin : g_bad_lane
            $error("bram_sdp_ctrl: DATA_W must be a multiple of BYTE_W");
        end
    endgenerate

    clr_state_t        r_state, w_state_nxt;
    logic [AW-1:0]     r_clr_cnt, w_clr_cnt_nxt;
    logic              r_init_pend, w_init_pend_nxt;
    logic              w_busy, w_wr_acc, w_rd_acc;
    logic              w_arr_we;
    logic [AW-1:0]     w_arr_waddr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [NB-1:0]     w_arr_wbe;
    logic [DATA_W-1:0] w_arr_rdata, w_s1_data;
    logic              r_v1;

    assign w_busy   = (r_state == CLEAR);
    assign busy     = w_busy;
    assign w_wr_acc = wr_en && !w_busy && (32'(wr_addr) < DEPTH_U);
    assign w_rd_acc = rd_en && !w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_init_pend <= (INIT_ZERO != 0);
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_init_pend <= w_init_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_init_pend_nxt = r_init_pend;
        w_arr_we        = w_wr_acc;
        w_arr_waddr     = wr_addr;
        w_arr_wdata     = wr_data;
        w_arr_wbe       = wr_be;
        case (r_state)
            IDLE: begin
                if (clr_req || r_init_pend) begin
                    w_state_nxt     = CLEAR;
                    w_clr_cnt_nxt   = '0;
                    w_init_pend_nxt = 1'b0;
                end
            end
            CLEAR: begin
                w_arr_we    = 1'b1;
                w_arr_waddr = r_clr_cnt;
                w_arr_wdata = '0;
                w_arr_wbe   = '1;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    bram_sdp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_wbe   (w_arr_wbe),
        .i_re    (w_rd_acc),
        .i_raddr (rd_addr),
        .o_rdata (w_arr_rdata)
    );

`ifdef BRAM_WR_FWD_EN
    // Forwarding state only advances with an accepted read so stage-1 data holds between reads.
    logic              r_fwd_hit;
    logic [DATA_W-1:0] r_fwd_data;
    logic [NB-1:0]     r_fwd_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
        end else if (w_rd_acc) begin
            r_fwd_hit  <= w_wr_acc && (wr_addr == rd_addr);
            r_fwd_data <= wr_data;
            r_fwd_be   <= wr_be;
        end
    end

    always_comb begin
        w_s1_data = w_arr_rdata;
        if (r_fwd_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (r_fwd_be[b]) w_s1_data[b*BYTE_W +: BYTE_W] = r_fwd_data[b*BYTE_W +: BYTE_W];
            end
        end
    end
`else
    assign w_s1_data = w_arr_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_v1 <= 1'b0;
        else     r_v1 <= w_rd_acc;
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_data  = w_s1_data;
            assign rd_valid = r_v1;
        end else begin : g_lat2
            logic              r_v2;
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2      <= 1'b0;
                    r_rd_data <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_rd_data <= w_s1_data;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_v2;
        end
    endgenerate

endmodule

// File: doc/bram_sdp_ctrl.md
BRAM_SDP_CTRL -- requirements
Module: bram_sdp_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, read/write data width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; any value >= 2, power of two not required.
REQ-003 SHALL have parameter BYTE_W, default 8, write-enable lane width; DATA_W SHALL be an integer multiple of BYTE_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_ZERO, default 1, auto-clear of the array after reset.
REQ-006 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  AW  write address; AW = clog2(DEPTH), minimum 1.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 wr_be  in  DATA_W/BYTE_W  per-lane write enable; bit i covers wr_data[i*BYTE_W +: BYTE_W].
REQ-012 rd_en  in  1  read request.
REQ-013 rd_addr  in  AW  read address.
REQ-014 rd_data  out  DATA_W  read data.
REQ-015 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-016 clr_req  in  1  one-cycle request to zero the whole array.
REQ-017 busy  out  1  clear in progress; host accesses ignored.

Function
REQ-018 Write: wr_en=1 and busy=0 at a rising edge SHALL update only the lanes with wr_be=1 at wr_addr; wr_be=0 lanes keep their old value.
REQ-019 Read: rd_en=1 and busy=0 in cycle N SHALL drive rd_data with the word at rd_addr and rd_valid=1 in cycle N+RD_LAT; one read per cycle, fully pipelined.
REQ-020 rd_data SHALL hold its last value when rd_valid=0.
REQ-021 Same-address write and read in one cycle SHALL return old data (read-first) unless REQ-030 applies.
REQ-022 Address >= DEPTH: write SHALL be dropped; read SHALL return all-zero data with rd_valid=1 at normal latency.
REQ-023 Clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1 or on the first cycle after rst deasserts when INIT_ZERO=1.
REQ-024 In CLEAR a counter SHALL write zero to address 0, 1, ... DEPTH-1, one word per cycle; after address DEPTH-1 it SHALL return to IDLE the next cycle; clear takes exactly DEPTH cycles.
REQ-025 busy SHALL be 1 exactly while in CLEAR; wr_en, rd_en and clr_req SHALL be ignored in CLEAR; reads already in the pipeline SHALL still complete.

Reset
REQ-026 During rst: rd_data=0, rd_valid=0, read pipeline flushed, clear counter=0.
REQ-027 During rst busy SHALL be 0; array contents SHALL NOT be altered by rst itself.
REQ-028 rst asserted during CLEAR SHALL abort it; with INIT_ZERO=1 the clear SHALL restart from address 0 after rst deasserts.
REQ-029 With INIT_ZERO=0 the FSM SHALL leave reset in IDLE, busy=0.

Configuration
REQ-030 Macro BRAM_WR_FWD_EN defined: same-address write and read in one cycle SHALL return merged data (new bytes where wr_be=1, old bytes elsewhere), write-first.
REQ-031 BRAM_WR_FWD_EN undefined: no forwarding logic, read-first per REQ-021.

Structure
REQ-032 Shared package bram_pkg SHALL hold the FSM state enum (IDLE, CLEAR), the clog2 function and the RD_LAT legality constants.
REQ-033 Storage array SHALL be a sub-module bram_sdp_array (registered read, per-lane write); control, clear FSM, latency pipeline and forwarding stay in bram_sdp_ctrl.

Verification
REQ-034 DEPTH=16, INIT_ZERO=1: release rst -> busy=1 for exactly 16 cycles; then reading all addresses returns 0x00000000.
REQ-035 Write 0xAABBCCDD to addr 3 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101 -> read addr 3 returns 0xAA22CC44, rd_valid exactly RD_LAT cycles after rd_en, for RD_LAT=1 and 2.
REQ-036 addr 5 holds 0x0; same cycle write 0xDEADBEEF and read addr 5 -> 0x00000000 without BRAM_WR_FWD_EN, 0xDEADBEEF with it.
REQ-037 DEPTH=12: write 0x55 to addr 13 -> dropped; read addr 13 -> 0x0 with rd_valid=1.
REQ-038 clr_req at cycle 0, rst at cycle 5 -> busy=0 during rst, clear restarts at address 0 after release, completes DEPTH cycles later; rd_en/wr_en during busy have no effect.
